// File: rtl/tensor_dpu_seq.sv
// ---------------------------------------------------------------------------
// tensor_dpu_seq
//   Multi-beat tensor dot-product unit: D = C + sum over beats of (A_k x B_k)
//   for an M x N tile, consuming KC reduction elements per beat. Signed
//   integer MAC, optional per-beat saturation, valid/ready on both sides.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   input beat handshake
//   in_first / in_last    operation delimiters (first beat loads c_tile)
//   a_tile                M x KC operands, element (i,k) at (i*KC+k)*IN_W
//   b_tile                KC x N operands, element (k,j) at (k*N+j)*IN_W
//   c_tile                M x N addend, element (i,j) at (i*N+j)*ACC_W
//   out_valid / out_ready result handshake
//   d_tile                M x N result, same layout as c_tile
//   out_beats             beats accumulated into d_tile
//   err                   one-cycle pulse on protocol error or beat overflow
// ---------------------------------------------------------------------------
module tensor_dpu_seq #(
    parameter int M         = 4,
    parameter int N         = 4,
    parameter int KC        = 2,
    parameter int IN_W      = 16,
    parameter int ACC_W     = 32,
    parameter int MAX_BEATS = 8,
    parameter int SATURATE  = 0,
    localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [M*KC*IN_W-1:0]   a_tile,
    input  logic [KC*N*IN_W-1:0]   b_tile,
    input  logic [M*N*ACC_W-1:0]   c_tile,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [M*N*ACC_W-1:0]   d_tile,
    output logic [CNT_W-1:0]       out_beats,
    output logic                   err
);

    // The per-beat dot product may exceed ACC_W (e.g. KC * (-2^15)^2 = 2^31),
    // so products and the beat addition are carried one bit wider than the
    // larger of the two operands; the clamp then sees the true sum.
    localparam int PROD_W = 2 * IN_W + $clog2(KC);
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX =
        {{(SUM_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN =
        {{(SUM_W - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_t;

    state_t                 state, state_n;
    logic [M*N*ACC_W-1:0]   acc, acc_n;
    logic [CNT_W-1:0]       count, new_count;
    logic                   accept, hit_max;
    logic                   load_acc, go_out, err_n;
    logic signed [SUM_W-1:0] psum, sum;

    assign accept    = in_valid && in_ready;
    // A first beat always restarts the count, even when abandoning an operation.
    assign new_count = in_first ? CNT_W'(1) : count + CNT_W'(1);
    assign hit_max   = (new_count == CNT_W'(MAX_BEATS));

    // Control: next state, handshake outputs and the error pulse.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_n   = state;
        load_acc  = 1'b0;
        go_out    = 1'b0;
        err_n     = 1'b0;
        in_ready  = 1'b1;
        out_valid = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_first) load_acc = 1'b1;
                    else          err_n    = 1'b1;   // beat without a start is dropped
                end
            end
            ACCUM: begin
                if (accept) begin
                    load_acc = 1'b1;
                    if (in_first) err_n = 1'b1;      // abandon and restart
                end
            end
            OUT: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (load_acc) begin
            if (in_last || hit_max) begin
                go_out  = 1'b1;
                state_n = OUT;
                if (!in_last) err_n = 1'b1;          // forced end at MAX_BEATS
            end else begin
                state_n = ACCUM;
            end
        end
    end

    // Datapath: next accumulator value for an accepted beat.
    always_comb begin
        acc_n = acc;
        psum  = '0;
        sum   = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                psum = '0;
                for (int k = 0; k < KC; k++) begin
                    psum = psum
                         + SUM_W'($signed(a_tile[(i*KC+k)*IN_W +: IN_W]))
                         * SUM_W'($signed(b_tile[(k*N+j)*IN_W +: IN_W]));
                end
                if (in_first)
                    sum = SUM_W'($signed(c_tile[(i*N+j)*ACC_W +: ACC_W])) + psum;
                else
                    sum = SUM_W'($signed(acc[(i*N+j)*ACC_W +: ACC_W])) + psum;

                if (SATURATE != 0 && sum > ACC_MAX)
                    acc_n[(i*N+j)*ACC_W +: ACC_W] = ACC_MAX[ACC_W-1:0];
                else if (SATURATE != 0 && sum < ACC_MIN)
                    acc_n[(i*N+j)*ACC_W +: ACC_W] = ACC_MIN[ACC_W-1:0];
                else
                    acc_n[(i*N+j)*ACC_W +: ACC_W] = sum[ACC_W-1:0];
            end
        end
    end

    // NOTE: the accumulator and result tile are reset even though they are
    // wide; a reset must leave d_tile at zero and discard any partial sum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            d_tile    <= '0;
            out_beats <= '0;
            err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state <= state_n;
            err   <= err_n;
            if (load_acc) begin
                acc   <= acc_n;
                count <= new_count;
            end
            if (go_out) begin
                d_tile    <= acc_n;
                out_beats <= new_count;
            end
        end
    end

endmodule
